// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter sanity checks for the parametrised FIFO.
package fifo_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the counter can hold DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int depth, input int af, input int ae);
        return (af > 0) && (af <= depth) && (ae >= 0) && (ae < depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; master = user logic, slave = FIFO.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic              clr;
    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr_en, din, rd_en,
        input  dout, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, din, rd_en,
        output dout, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// Register-file storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with flush, occupancy, sticky error flags and
// a choice of registered or first-word-fall-through read path.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                clk,
    input  logic                rst,
    sync_fifo_param_if.slave    bus
);
    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_param: almost-flag thresholds out of range");
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              wr_acc, rd_acc, empty_w, full_w;
    logic [DATA_W-1:0] ram_rdata;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));
    assign rd_acc  = bus.rd_en && !empty_w;
    // A write into a full FIFO is fine when a read frees the slot in the same edge.
    assign wr_acc  = bus.wr_en && (!full_w || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_acc && !rd_acc) begin
                count_d = count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - 1'b1;
            end
            if (bus.wr_en && !wr_acc) overflow_d  = 1'b1;
            if (bus.rd_en && !rd_acc) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(.DATA_W(DATA_W), .ADDR_W(AW)) u_ram (
        .clk   (clk),
        .we    (wr_acc && !bus.clr),
        .waddr (wr_ptr_q),
        .wdata (bus.din),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign bus.count        = count_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    if (FWFT != 0) begin : g_fwft
        // Head is shown directly; forced to zero while empty so reset reads back 0.
        assign bus.dout  = empty_w ? '0 : ram_rdata;
        assign bus.valid = !empty_w;
    end else begin : g_reg
        logic [DATA_W-1:0] dout_q, dout_d;
        logic              valid_q, valid_d;

        always_comb begin
            dout_d  = dout_q;
            valid_d = 1'b0;
            if (rd_acc && !bus.clr) begin
                dout_d  = ram_rdata;
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= valid_d;
            end
        end

        assign bus.dout  = dout_q;
        assign bus.valid = valid_q;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: one registered-read FIFO and one FWFT FIFO, both 16x8.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus_a ();
    sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus_b ();

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
        $display("t=%0t a: wr=%b din=%02h rd=%b clr=%b -> cnt=%0d dout=%02h v=%b | b: wr=%b rd=%b -> cnt=%0d dout=%02h v=%b",
                 $time, bus_a.wr_en, bus_a.din, bus_a.rd_en, bus_a.clr, bus_a.count, bus_a.dout, bus_a.valid,
                 bus_b.wr_en, bus_b.rd_en, bus_b.count, bus_b.dout, bus_b.valid);
    endtask

    initial begin
        bus_a.clr = 0; bus_a.wr_en = 0; bus_a.din = 0; bus_a.rd_en = 0;
        bus_b.clr = 0; bus_b.wr_en = 0; bus_b.din = 0; bus_b.rd_en = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        check("rst_count", bus_a.count, 0);
        check("rst_empty", bus_a.empty, 1);
        check("rst_aempty", bus_a.almost_empty, 1);
        check("rst_full", bus_a.full, 0);
        check("rst_afull", bus_a.almost_full, 0);
        check("rst_dout", bus_a.dout, 0);
        check("rst_valid", bus_a.valid, 0);
        check("rst_ovf", bus_a.overflow, 0);
        check("rst_udf", bus_a.underflow, 0);
        check("rst_b_valid", bus_b.valid, 0);

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            bus_a.wr_en = 1; bus_a.din = 8'(i);
            cyc();
            check($sformatf("fill_count_%0d", i), bus_a.count, i);
            check($sformatf("fill_afull_%0d", i), bus_a.almost_full, (i >= 14) ? 1 : 0);
            check($sformatf("fill_aempty_%0d", i), bus_a.almost_empty, (i <= 2) ? 1 : 0);
            check($sformatf("fill_full_%0d", i), bus_a.full, (i == 16) ? 1 : 0);
            check($sformatf("fill_empty_%0d", i), bus_a.empty, 0);
        end
        bus_a.din = 8'h11;
        cyc();
        check("ovf_set", bus_a.overflow, 1);
        check("ovf_count", bus_a.count, 16);
        check("ovf_udf", bus_a.underflow, 0);
        bus_a.wr_en = 0;

        // Drain with isolated reads to see each 1-cycle valid pulse
        for (int i = 1; i <= 16; i++) begin
            bus_a.rd_en = 1;
            cyc();
            check($sformatf("drain_dout_%0d", i), bus_a.dout, i);
            check($sformatf("drain_valid_%0d", i), bus_a.valid, 1);
            check($sformatf("drain_count_%0d", i), bus_a.count, 16 - i);
            check($sformatf("drain_full_%0d", i), bus_a.full, 0);
            bus_a.rd_en = 0;
            cyc();
            check($sformatf("drain_vlow_%0d", i), bus_a.valid, 0);
            check($sformatf("drain_hold_%0d", i), bus_a.dout, i);
        end
        check("drain_empty", bus_a.empty, 1);
        bus_a.rd_en = 1;
        cyc();
        bus_a.rd_en = 0;
        check("udf_set", bus_a.underflow, 1);
        check("udf_count", bus_a.count, 0);
        check("udf_valid", bus_a.valid, 0);
        check("udf_ovf_sticky", bus_a.overflow, 1);

        // Five entries with both flags set, then clr alongside a write
        for (int i = 0; i < 5; i++) begin
            bus_a.wr_en = 1; bus_a.din = 8'(8'h21 + i);
            cyc();
        end
        check("pre_clr_count", bus_a.count, 5);
        check("pre_clr_ovf", bus_a.overflow, 1);
        check("pre_clr_udf", bus_a.underflow, 1);
        bus_a.clr = 1; bus_a.din = 8'h77;
        cyc();
        bus_a.clr = 0; bus_a.wr_en = 0;
        check("clr_count", bus_a.count, 0);
        check("clr_empty", bus_a.empty, 1);
        check("clr_ovf", bus_a.overflow, 0);
        check("clr_udf", bus_a.underflow, 0);
        check("clr_valid", bus_a.valid, 0);

        // Fill 0x40..0x4F, then simultaneous read/write at full across the wrap
        for (int i = 0; i < 16; i++) begin
            bus_a.wr_en = 1; bus_a.din = 8'(8'h40 + i);
            cyc();
        end
        check("wrap_full", bus_a.full, 1);
        for (int k = 0; k < 4; k++) begin
            bus_a.wr_en = 1; bus_a.rd_en = 1; bus_a.din = 8'(8'h50 + k);
            cyc();
            check($sformatf("rw_dout_%0d", k), bus_a.dout, 8'h40 + k);
            check($sformatf("rw_count_%0d", k), bus_a.count, 16);
            check($sformatf("rw_ovf_%0d", k), bus_a.overflow, 0);
        end
        bus_a.wr_en = 0;
        for (int i = 0; i < 16; i++) begin
            bus_a.rd_en = 1;
            cyc();
            check($sformatf("wrap_dout_%0d", i), bus_a.dout, (i < 12) ? (8'h44 + i) : (8'h50 + i - 12));
            check($sformatf("wrap_valid_%0d", i), bus_a.valid, 1);
        end
        bus_a.rd_en = 0;
        check("wrap_empty", bus_a.empty, 1);
        check("wrap_udf", bus_a.underflow, 0);

        // Async reset mid-cycle at count 7
        for (int i = 0; i < 7; i++) begin
            bus_a.wr_en = 1; bus_a.din = 8'(8'h60 + i);
            cyc();
        end
        bus_a.wr_en = 0;
        check("pre_rst_count", bus_a.count, 7);
        #2 rst = 1'b1;
        #1;
        check("arst_count", bus_a.count, 0);
        check("arst_empty", bus_a.empty, 1);
        check("arst_aempty", bus_a.almost_empty, 1);
        check("arst_dout", bus_a.dout, 0);
        check("arst_valid", bus_a.valid, 0);
        #1 rst = 1'b0;
        bus_a.wr_en = 1; bus_a.din = 8'h70;
        cyc();
        bus_a.din = 8'h71;
        cyc();
        bus_a.wr_en = 0; bus_a.rd_en = 1;
        cyc();
        check("post_rst_rd0", bus_a.dout, 8'h70);
        cyc();
        check("post_rst_rd1", bus_a.dout, 8'h71);
        bus_a.rd_en = 0;
        cyc();
        check("post_rst_empty", bus_a.empty, 1);

        // FWFT instance
        check("fwft_idle_empty", bus_b.empty, 1);
        bus_b.wr_en = 1; bus_b.din = 8'hA5;
        cyc();
        bus_b.wr_en = 0;
        check("fwft_dout", bus_b.dout, 8'hA5);
        check("fwft_valid", bus_b.valid, 1);
        check("fwft_count", bus_b.count, 1);
        bus_b.rd_en = 1;
        cyc();
        bus_b.rd_en = 0;
        check("fwft_pop_empty", bus_b.empty, 1);
        check("fwft_pop_valid", bus_b.valid, 0);
        bus_b.wr_en = 1; bus_b.din = 8'hB1;
        cyc();
        bus_b.din = 8'hB2;
        cyc();
        bus_b.wr_en = 0;
        check("fwft_head1", bus_b.dout, 8'hB1);
        bus_b.rd_en = 1;
        cyc();
        bus_b.rd_en = 0;
        check("fwft_head2", bus_b.dout, 8'hB2);
        check("fwft_count2", bus_b.count, 1);
        bus_b.rd_en = 1;
        cyc();
        bus_b.rd_en = 1;
        cyc();
        bus_b.rd_en = 0;
        check("fwft_udf", bus_b.underflow, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
